control_seq: RTL

Parametrised next-generation instruction sequencer for the RISC CPU control path. Steps each instruction through eight phases and drives the pad-level strobes (rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel). Adds three things over the fixed eight-cycle controller:
- memory wait states with a timeout;
- a resumable halted state;
- single-step debug.

Sits between the input pad cells (opcode, zero, mem_rdy, debug inputs) and the output pad cells.

---
 rtl/control_seq_if.sv | 34 +++
 rtl/control_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/control_seq_if.sv
// rtl/control_seq_if.sv - pad-side signal bundle for the instruction sequencer
interface control_seq_if;
  // Inputs from the pad cells
  logic [2:0] opcode;
  logic       zero;
  logic       mem_rdy;
  logic       step_mode;
  logic       step;
  logic       run;
  // Control strobes toward the output pad cells
  logic       rd;
  logic       wr;
  logic       ld_ir;
  logic       ld_ac;
  logic       ld_pc;
  logic       inc_pc;
  logic       halt;
  logic       data_e;
  logic       sel;
  logic       bus_err;
  logic [3:0] phase;

  // Sequencer side: consumes pad inputs, drives strobes
  modport master (
    input  opcode, zero, mem_rdy, step_mode, step, run,
    output rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel, bus_err, phase
  );

  // Pad / environment side
  modport slave (
    output opcode, zero, mem_rdy, step_mode, step, run,
    input  rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel, bus_err, phase
  );
endinterface

// File: rtl/control_seq.sv
// rtl/control_seq.sv - eight-phase instruction sequencer with wait states, halt/resume and single-step
module control_seq #(
  parameter int WAIT_W       = 4,
  parameter int MAX_WAIT     = 15,
  parameter bit RUN_AT_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst_,
  control_seq_if.master bus
);

  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8,
    S_PAUSE      = 4'd9
  } state_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam bit                TIMEOUT_EN = (MAX_WAIT != 0);
  localparam state_e            RESET_ST   = RUN_AT_RESET ? S_INST_ADDR : S_HALTED;

  state_e            state_q, state_d;
  logic [2:0]        opc_q, opc_d;
  logic              zero_q, zero_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              bus_err_q, bus_err_d;
  logic              aluop;

  // State register and latched instruction context; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= RESET_ST;
      opc_q     <= 3'd0;
      zero_q    <= 1'b0;
      wcnt_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      zero_q    <= zero_d;
      wcnt_q    <= wcnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state: phase stepping, wait/timeout handling, halt/resume and pause
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    zero_d    = zero_q;
    wcnt_d    = wcnt_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_INST_ADDR: begin
        state_d = S_INST_FETCH;
        wcnt_d  = '0;
      end
      S_INST_FETCH: begin
        // mem_rdy takes priority over an expiring timeout
        if (bus.mem_rdy) begin
          state_d = S_INST_LOAD;
        end else if (TIMEOUT_EN && (wcnt_q == MAX_WAIT_C)) begin
          state_d   = S_HALTED;
          bus_err_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WAIT_W'(1);
        end
      end
      S_INST_LOAD: state_d = S_IDLE;
      S_IDLE: begin
        state_d = S_OP_ADDR;
        opc_d   = bus.opcode;
      end
      S_OP_ADDR: begin
        // PC is already incremented here, so a later resume runs the next instruction
        state_d = (opc_q == OP_HLT) ? S_HALTED : S_OP_FETCH;
        wcnt_d  = '0;
      end
      S_OP_FETCH: begin
        if (bus.mem_rdy) begin
          state_d = S_ALU_OP;
          zero_d  = bus.zero;
        end else if (TIMEOUT_EN && (wcnt_q == MAX_WAIT_C)) begin
          state_d   = S_HALTED;
          bus_err_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WAIT_W'(1);
        end
      end
      S_ALU_OP: state_d = S_STORE;
      S_STORE:  state_d = bus.step_mode ? S_PAUSE : S_INST_ADDR;
      S_HALTED: begin
        if (bus.run) begin
          state_d   = S_INST_ADDR;
          bus_err_d = 1'b0;
        end
      end
      S_PAUSE: begin
        if (bus.step || !bus.step_mode) state_d = S_INST_ADDR;
      end
      default: begin
        state_d   = S_HALTED;
        bus_err_d = 1'b1;
      end
    endcase
  end

  assign bus.phase   = state_q;
  assign bus.bus_err = bus_err_q;

  // Output decode purely from flops so no pad input reaches a strobe combinationally
  always_comb begin
    aluop       = (opc_q == OP_ADD) || (opc_q == OP_AND) ||
                  (opc_q == OP_XOR) || (opc_q == OP_LDA);
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.ld_ir   = 1'b0;
    bus.ld_ac   = 1'b0;
    bus.ld_pc   = 1'b0;
    bus.inc_pc  = 1'b0;
    bus.halt    = 1'b0;
    bus.data_e  = 1'b0;
    bus.sel     = 1'b0;
    case (state_q)
      S_INST_ADDR: bus.sel = 1'b1;
      S_INST_FETCH: begin
        bus.sel = 1'b1;
        bus.rd  = 1'b1;
      end
      S_INST_LOAD, S_IDLE: begin
        bus.sel   = 1'b1;
        bus.rd    = 1'b1;
        bus.ld_ir = 1'b1;
      end
      S_OP_ADDR: begin
        bus.inc_pc = 1'b1;
        bus.halt   = (opc_q == OP_HLT);
      end
      S_OP_FETCH: bus.rd = aluop;
      S_ALU_OP: begin
        bus.rd     = aluop;
        bus.inc_pc = (opc_q == OP_SKZ) && zero_q;
        bus.ld_pc  = (opc_q == OP_JMP);
        bus.data_e = (opc_q == OP_STO);
      end
      S_STORE: begin
        bus.rd     = aluop;
        bus.ld_ac  = aluop;
        bus.ld_pc  = (opc_q == OP_JMP);
        bus.wr     = (opc_q == OP_STO);
        bus.data_e = (opc_q == OP_STO);
      end
      S_HALTED: bus.halt = 1'b1;
      default: ;
    endcase
  end

endmodule
